// File: rtl/logic_operand_entry_pkg.sv
// Shared calculator definitions: one-hot logic opcodes, entry-stage codes
// and a one-hot test used when the operator confirms an opcode.
package logic_operand_entry_pkg;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b1000;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_DONE = 3'd3
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/logic_operand_entry_btn_debounce.sv
// Button debouncer: the level follows the raw input only after it has
// differed for DEBOUNCE_CYCLES+1 consecutive clocks; a rise gives one pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             pulse_r;
    logic             armed_r;

    // Counter, debounced level and press pulse; a press must start from a
    // released button, so one held through reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            if (!btn_raw) begin
                armed_r <= 1'b1;
            end
            if (btn_raw == level_r) begin
                cnt_r <= CNT_ZERO;
            end else if (btn_raw && !armed_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r   <= CNT_ZERO;
                level_r <= btn_raw;
                pulse_r <= btn_raw;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign btn_level = level_r;
    assign btn_pulse = pulse_r;

endmodule

// File: rtl/logic_operand_entry.sv
// Operator front end of the logic calculator: debounced confirm/back buttons
// step through opcode, operand A and operand B entry, then hold the result.
module logic_operand_entry
    import logic_operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic [3:0] op_sw,
    input  logic       btn_confirm,
    input  logic       btn_back,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [3:0] op,
    output logic       operands_valid,
    output logic [2:0] stage,
    output logic       op_err
);

    logic confirm_level_s, confirm_pulse_s;
    logic back_level_s, back_pulse_s;
    logic confirm_s, back_s;

    state_t     state_r, state_next_s;
    logic [7:0] a_r, a_next_s;
    logic [7:0] b_r, b_next_s;
    logic [3:0] op_r, op_next_s;
    logic       valid_r;
    logic       op_err_r, op_err_next_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_confirm (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_confirm),
        .btn_level (confirm_level_s),
        .btn_pulse (confirm_pulse_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_back (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_back),
        .btn_level (back_level_s),
        .btn_pulse (back_pulse_s)
    );

    // A pulse is only trusted while its debounced level agrees with it.
    assign confirm_s = confirm_pulse_s & confirm_level_s;
    assign back_s    = back_pulse_s & back_level_s;

    // Next-state and operand updates; back takes priority over confirm.
    always_comb begin
        state_next_s  = state_r;
        a_next_s      = a_r;
        b_next_s      = b_r;
        op_next_s     = op_r;
        op_err_next_s = 1'b0;
        if (back_s) begin
            case (state_r)
                S_OP:    state_next_s = S_OP;
                S_A:     state_next_s = S_OP;
                S_B:     state_next_s = S_A;
                S_DONE:  state_next_s = (op_r == OP_NOT) ? S_A : S_B;
                default: state_next_s = S_OP;
            endcase
        end else if (confirm_s) begin
            case (state_r)
                S_OP: begin
                    if (is_onehot4(op_sw)) begin
                        op_next_s    = op_sw;
                        state_next_s = S_A;
                    end else begin
                        op_err_next_s = 1'b1;
                    end
                end
                S_A: begin
                    a_next_s = sw;
                    if (op_r == OP_NOT) begin
                        b_next_s     = 8'h00;
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_B;
                    end
                end
                S_B: begin
                    b_next_s     = sw;
                    state_next_s = S_DONE;
                end
                S_DONE: begin
                    a_next_s     = 8'h00;
                    b_next_s     = 8'h00;
                    op_next_s    = 4'b0000;
                    state_next_s = S_OP;
                end
                default: state_next_s = S_OP;
            endcase
        end else begin
            case (state_r)
                S_OP, S_A, S_B, S_DONE: state_next_s = state_r;
                default:                state_next_s = S_OP;
            endcase
        end
    end

    // State, operand and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_OP;
            a_r      <= 8'h00;
            b_r      <= 8'h00;
            op_r     <= 4'b0000;
            valid_r  <= 1'b0;
            op_err_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            a_r      <= a_next_s;
            b_r      <= b_next_s;
            op_r     <= op_next_s;
            valid_r  <= (state_next_s == S_DONE);
            op_err_r <= op_err_next_s;
        end
    end

    assign a              = a_r;
    assign b              = b_r;
    assign op             = op_r;
    assign operands_valid = valid_r;
    assign stage          = state_r;
    assign op_err         = op_err_r;

endmodule
